// File: rtl/hexport_pkg.sv
// Shared types and sizing helpers for the HEX display port arbiter.
package hexport_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned NREQ_MAX = 8;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PTR_W_MAX = ptr_width(NREQ_MAX);

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above start, wrapping modulo NREQ.
module rr_pick import hexport_pkg::*; #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   start,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  always_comb begin
    logic          found;
    logic [PW-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = PW'((32'(start) + k) % NREQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/hexport_arbiter.sv
// Round-robin arbiter with optional lock and watchdog sharing the HEX display
// register between several byte-enabled write requesters.
module hexport_arbiter import hexport_pkg::*; #(
  parameter int unsigned  NREQ         = 2,
  parameter int unsigned  W            = 32,
  parameter int unsigned  LOCK_TIMEOUT = 1024,
  parameter logic [W-1:0] RESET_VAL    = '1,
  parameter int unsigned  PW           = ptr_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*(W/8)-1:0] req_be,
  input  logic [NREQ*W-1:0]     req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [W-1:0]          hex_out,
  output logic [PW-1:0]         owner,
  output logic                  lock_active,
  output logic                  timeout_pulse
);

  localparam int unsigned NB = W / 8;
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    hex_q, hex_d;
  logic            pulse_q, pulse_d;

  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] lock_ready;
  logic [PW-1:0]   sel_idx;
  logic [W-1:0]    sel_data;
  logic [NB-1:0]   sel_be;
  logic            sel_lock;
  logic            commit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (32'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .start (rr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    lock_ready          = '0;
    lock_ready[owner_q] = req_valid[owner_q];
    req_ready           = '0;
    if (reset_n)
      req_ready = (state_q == LOCKED) ? lock_ready : pick_grant;
    commit  = |req_ready;
    sel_idx = (state_q == LOCKED) ? owner_q : pick_idx;
    sel_data = '0;
    sel_be   = '0;
    sel_lock = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == sel_idx) begin
        sel_data = req_data[i*W +: W];
        sel_be   = req_be[i*NB +: NB];
        sel_lock = req_lock[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    pulse_d = 1'b0;

    if (commit) begin
      for (int unsigned k = 0; k < NB; k++)
        if (sel_be[k]) hex_d[8*k +: 8] = sel_data[8*k +: 8];
    end

    unique case (state_q)
      IDLE: begin
        if (commit) begin
          rr_d = next_ptr(sel_idx);
          if (sel_lock) begin
            state_d = LOCKED;
            owner_d = sel_idx;
            cnt_d   = '0;
          end
        end
      end
      LOCKED: begin
        // Owner commit beats both voluntary release and watchdog expiry.
        if (commit) begin
          cnt_d = '0;
          if (!sel_lock) begin
            state_d = IDLE;
            owner_d = '0;
          end
        end else if (!req_lock[owner_q]) begin
          state_d = IDLE;
          owner_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = IDLE;
          pulse_d = 1'b1;
          rr_d    = next_ptr(owner_q);
          owner_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      hex_q   <= RESET_VAL;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      pulse_q <= pulse_d;
    end
  end

  assign hex_out       = hex_q;
  assign owner         = owner_q;
  assign lock_active   = (state_q == LOCKED);
  assign timeout_pulse = pulse_q;

endmodule

// File: doc/hexport_arbiter.md
# hexport_arbiter

- Shares the single 32-bit HEX display output port of the PCIe hello core between several write requesters, e.g. the PCIe BAR master and a local pattern sequencer.
- Uses round-robin arbitration, with an optional per-requester lock for multi-write sequences and a watchdog that releases a stuck lock.
- Holds the display register, merges writes by byte enable, and drives `hexrport_external_connection_export` on the top level.

## Interface

Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `W`, 32: display register width; must equal 8 × number of byte lanes.
- `LOCK_TIMEOUT`, 1024: cycles a lock may stay idle before forced release (≥2).
- `RESET_VAL`, 32'hFFFF_FFFF: display value after reset (all segments off, active-low segments).

Ports:
- `clk` in 1: single clock; reset is synchronous and active-low.
- `reset_n` in 1: synchronous active-low reset.
- `req_valid` in NREQ: per-requester write request.
- `req_lock` in NREQ: requester wants to keep ownership after this write.
- `req_be` in NREQ×(W/8): byte enables; requester i uses slice [i×W/8 +: W/8].
- `req_data` in NREQ×W: write data; requester i uses slice [i×W +: W].
- `req_ready` out NREQ: grant; a write commits on the edge where valid & ready are both high.
- `hex_out` out W: display register.
- `owner` out clog2(NREQ): current lock owner; 0 when unlocked.
- `lock_active` out 1: high in LOCKED.
- `timeout_pulse` out 1: one-cycle pulse on forced release.

## Operation

- **States:** IDLE and LOCKED.
- **IDLE, winner selection:** the winner is the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo NREQ.
- **IDLE, grant:** `req_ready` is high for the winner only (one-hot, combinational from inputs and state). No requester is valid → `req_ready`=0.
- **Commit:** `hex_out[8k+:8]` ← data byte k for every set `req_be[k]`. Bytes with enable clear keep their value. `req_be`=0 still completes the handshake but leaves `hex_out` unchanged.
- **IDLE commit:** `rr_ptr` ← winner+1 mod NREQ.
- **Entering LOCKED:** an IDLE commit with `req_lock`=1 moves to LOCKED, sets `owner` ← winner and clears the watchdog counter.
- **LOCKED, grant:** `req_ready` = `req_valid[owner]` only; all other requesters stall with `req_ready` low.
- **LOCKED, owner commit:** clears the watchdog counter.
- **LOCKED, release:**
  - Owner commits with `req_lock`=0 → IDLE.
  - Owner has `req_valid`=0 and `req_lock`=0 → IDLE.
  - `rr_ptr` is already owner+1 from the entering commit and is not changed on release.
- **Watchdog:** the counter increments every LOCKED cycle without an owner commit. When it reaches LOCK_TIMEOUT−1 → IDLE, `timeout_pulse` for one cycle, and `rr_ptr` ← owner+1.
- **Reset, all outputs:** `hex_out`=RESET_VAL, `req_ready`=0 for the reset cycle, `owner`=0, `lock_active`=0, `timeout_pulse`=0.
- **Reset, internal state:** state=IDLE, `rr_ptr`=0, counter=0. Reset mid-lock aborts the lock with no pulse.

## Timing

- `req_ready` is combinational. All other outputs are registered.
- Latency: commit edge → `hex_out` visible the same edge (registered), i.e. the next cycle.
- A requester holding `req_valid` must keep data, be and lock stable until it sees `req_ready` high. Withdrawing `req_valid` before the grant is allowed.
- One commit per cycle maximum; back-to-back commits are allowed in both states.
- **Simultaneous events:**
  - Owner commit in the same cycle the counter would expire → the commit wins, counter clears, no timeout.
  - Owner commit with lock=0 while others wait → they are eligible in the cycle after.
- **Release takes one cycle:** the cycle after release is IDLE with the new priority, so there is no same-cycle regrant.

## Structure

- Shared package `hexport_pkg`: state enum (IDLE, LOCKED), `NREQ_MAX`=8, helper constant for pointer width.
- Sub-module `rr_pick`: parameter NREQ.
  - Inputs: request vector, start pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; it is reused later by the switch-read path.
- The top contains the state register, `rr_ptr`, watchdog counter and byte-merge datapath.

## Test plan

- **Reset value:** hold `reset_n`=0 for 2 cycles → `hex_out`=FFFF_FFFF and `req_ready`=0. After release with no requests, nothing changes.
- **Round-robin fairness:** both requesters valid continuously with be=F and lock=0, data req0=1111_1111, req1=2222_2222 → grants alternate 0,1,0,1. `hex_out` follows with one-cycle lag.
- **Byte merge:** req0 writes 1234_5678 with be=F, then AB00_0000 with be=8 → `hex_out`=AB34_5678. A write with be=0 → value unchanged and `req_ready` still pulses.
- **Lock:** req0 writes with lock=1 while req1 is valid → req1 `req_ready` stays 0 across three req0 locked writes. req0 then writes with lock=0 → req1 is granted the following cycle.
- **Watchdog:** LOCK_TIMEOUT=16; req0 locks then idles → `timeout_pulse` after 16 LOCKED cycles and `lock_active`=0, then req1 is granted. Repeat with a req0 commit in the expiry cycle → no pulse.
- **Reset mid-lock:** reset while LOCKED with `hex_out`=0000_00FF → state IDLE, `hex_out`=FFFF_FFFF, `timeout_pulse` stays 0, first grant after reset goes to req0.
